// File: rtl/rs_issue_sched_if.sv
// rtl/rs_issue_sched_if.sv - dispatch, CDB, flush and issue bundle for rs_issue_sched
// master: dispatch/CDB/flush producer side, observes full and the issue bundle.
// slave : the reservation-station scheduler.
interface rs_issue_sched_if #(
  parameter int OP_W   = 6,
  parameter int DATA_W = 32,
  parameter int TAG_W  = 4
);
  logic              flush;
  logic              disp_valid;
  logic [OP_W-1:0]   disp_op;
  logic [DATA_W-1:0] disp_v1;
  logic [DATA_W-1:0] disp_v2;
  logic [TAG_W-1:0]  disp_q1;
  logic [TAG_W-1:0]  disp_q2;
  logic              disp_b1;
  logic              disp_b2;
  logic [DATA_W-1:0] disp_imm;
  logic [DATA_W-1:0] disp_pc;
  logic [TAG_W-1:0]  disp_tag;
  logic              cdb_valid;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_data;
  logic              full;
  logic              iss_valid;
  logic [OP_W-1:0]   iss_op;
  logic [DATA_W-1:0] iss_v1;
  logic [DATA_W-1:0] iss_v2;
  logic [DATA_W-1:0] iss_imm;
  logic [DATA_W-1:0] iss_pc;
  logic [TAG_W-1:0]  iss_tag;

  modport master (
    output flush, disp_valid, disp_op, disp_v1, disp_v2, disp_q1, disp_q2,
           disp_b1, disp_b2, disp_imm, disp_pc, disp_tag,
           cdb_valid, cdb_tag, cdb_data,
    input  full, iss_valid, iss_op, iss_v1, iss_v2, iss_imm, iss_pc, iss_tag
  );

  modport slave (
    input  flush, disp_valid, disp_op, disp_v1, disp_v2, disp_q1, disp_q2,
           disp_b1, disp_b2, disp_imm, disp_pc, disp_tag,
           cdb_valid, cdb_tag, cdb_data,
    output full, iss_valid, iss_op, iss_v1, iss_v2, iss_imm, iss_pc, iss_tag
  );
endinterface

// File: rtl/rs_issue_sched.sv
// rtl/rs_issue_sched.sv - integer ALU reservation station with CDB wakeup and oldest-slot-first select
// Ports: clk, rst_n (async active-low), sif (rs_issue_sched_if.slave):
//   flush, disp_* dispatch request, cdb_* result broadcast in;
//   full and the registered iss_* issue bundle out.
module rs_issue_sched #(
  parameter int ENTRIES = 8,
  parameter int OP_W    = 6,
  parameter int DATA_W  = 32,
  parameter int TAG_W   = 4
) (
  input logic              clk,
  input logic              rst_n,
  rs_issue_sched_if.slave  sif
);
  localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  logic [ENTRIES-1:0] busy;
  logic [ENTRIES-1:0] b1;
  logic [ENTRIES-1:0] b2;
  logic [ENTRIES-1:0] ready;
  logic [OP_W-1:0]    op  [ENTRIES];
  logic [DATA_W-1:0]  v1  [ENTRIES];
  logic [DATA_W-1:0]  v2  [ENTRIES];
  logic [DATA_W-1:0]  imm [ENTRIES];
  logic [DATA_W-1:0]  pc  [ENTRIES];
  logic [TAG_W-1:0]   q1  [ENTRIES];
  logic [TAG_W-1:0]   q2  [ENTRIES];
  logic [TAG_W-1:0]   tag [ENTRIES];

  logic [IDX_W-1:0]   sel_idx;
  logic               sel_any;
  logic [IDX_W-1:0]   free_idx;
  logic               free_any;
  logic [ENTRIES-1:0] iss_oh;
  logic [ENTRIES-1:0] disp_oh;

  logic              disp_hit1;
  logic              disp_hit2;

  logic              iss_valid_q;
  logic [OP_W-1:0]   iss_op_q;
  logic [DATA_W-1:0] iss_v1_q;
  logic [DATA_W-1:0] iss_v2_q;
  logic [DATA_W-1:0] iss_imm_q;
  logic [DATA_W-1:0] iss_pc_q;
  logic [TAG_W-1:0]  iss_tag_q;

  // Readiness uses the start-of-cycle operand flags, so a wakeup or dispatch
  // at this edge only becomes selectable one cycle later.
  assign ready    = busy & ~b1 & ~b2;
  assign sif.full = &busy;

  // Downward scan leaves the lowest matching index in the result.
  always_comb begin
    sel_idx  = '0;
    sel_any  = 1'b0;
    free_idx = '0;
    free_any = 1'b0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (ready[i]) begin
        sel_idx = IDX_W'(i);
        sel_any = 1'b1;
      end
      if (!busy[i]) begin
        free_idx = IDX_W'(i);
        free_any = 1'b1;
      end
    end
  end

  always_comb begin
    iss_oh  = '0;
    disp_oh = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      iss_oh[i]  = sel_any && (sel_idx == IDX_W'(i));
      disp_oh[i] = sif.disp_valid && free_any && (free_idx == IDX_W'(i));
    end
  end

  // Same-cycle bypass: a pending dispatch operand whose producer broadcasts now.
  assign disp_hit1 = sif.disp_b1 && sif.cdb_valid && (sif.disp_q1 == sif.cdb_tag);
  assign disp_hit2 = sif.disp_b2 && sif.cdb_valid && (sif.disp_q2 == sif.cdb_tag);

  // The issue slot is always busy and the dispatch slot never is, so the two
  // one-hot vectors cannot collide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy        <= '0;
      iss_valid_q <= 1'b0;
      iss_op_q    <= '0;
      iss_v1_q    <= '0;
      iss_v2_q    <= '0;
      iss_imm_q   <= '0;
      iss_pc_q    <= '0;
      iss_tag_q   <= '0;
    end else if (sif.flush) begin
      busy        <= '0;
      iss_valid_q <= 1'b0;
      iss_op_q    <= '0;
      iss_v1_q    <= '0;
      iss_v2_q    <= '0;
      iss_imm_q   <= '0;
      iss_pc_q    <= '0;
      iss_tag_q   <= '0;
    end else begin
      busy        <= (busy & ~iss_oh) | disp_oh;
      iss_valid_q <= sel_any;
      iss_op_q    <= sel_any ? op[sel_idx]  : '0;
      iss_v1_q    <= sel_any ? v1[sel_idx]  : '0;
      iss_v2_q    <= sel_any ? v2[sel_idx]  : '0;
      iss_imm_q   <= sel_any ? imm[sel_idx] : '0;
      iss_pc_q    <= sel_any ? pc[sel_idx]  : '0;
      iss_tag_q   <= sel_any ? tag[sel_idx] : '0;
    end
  end

  // Payload is only meaningful while busy is set, so it carries no reset.
  // Writes during a flush are harmless because busy is cleared at the same edge.
  always_ff @(posedge clk) begin
    for (int i = 0; i < ENTRIES; i++) begin
      if (disp_oh[i]) begin
        op[i]  <= sif.disp_op;
        imm[i] <= sif.disp_imm;
        pc[i]  <= sif.disp_pc;
        tag[i] <= sif.disp_tag;
        q1[i]  <= sif.disp_q1;
        q2[i]  <= sif.disp_q2;
        v1[i]  <= disp_hit1 ? sif.cdb_data : sif.disp_v1;
        v2[i]  <= disp_hit2 ? sif.cdb_data : sif.disp_v2;
        b1[i]  <= sif.disp_b1 && !disp_hit1;
        b2[i]  <= sif.disp_b2 && !disp_hit2;
      end else begin
        if (busy[i] && b1[i] && sif.cdb_valid && (q1[i] == sif.cdb_tag)) begin
          v1[i] <= sif.cdb_data;
          b1[i] <= 1'b0;
        end
        if (busy[i] && b2[i] && sif.cdb_valid && (q2[i] == sif.cdb_tag)) begin
          v2[i] <= sif.cdb_data;
          b2[i] <= 1'b0;
        end
      end
    end
  end

  assign sif.iss_valid = iss_valid_q;
  assign sif.iss_op    = iss_op_q;
  assign sif.iss_v1    = iss_v1_q;
  assign sif.iss_v2    = iss_v2_q;
  assign sif.iss_imm   = iss_imm_q;
  assign sif.iss_pc    = iss_pc_q;
  assign sif.iss_tag   = iss_tag_q;
endmodule

// File: tb/tb_rs_issue_sched.sv
// tb/tb_rs_issue_sched.sv - directed and randomized bench for rs_issue_sched with a slot-table reference model
module tb_rs_issue_sched;
  localparam int ENTRIES = 8;
  localparam int OP_W    = 6;
  localparam int DATA_W  = 32;
  localparam int TAG_W   = 4;
  localparam logic [OP_W-1:0] OP_ADD = 6'd1;

  typedef struct packed {
    logic              busy;
    logic              b1;
    logic              b2;
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] v1;
    logic [DATA_W-1:0] v2;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] pc;
    logic [TAG_W-1:0]  q1;
    logic [TAG_W-1:0]  q2;
    logic [TAG_W-1:0]  tag;
  } ent_t;

  typedef struct packed {
    logic              valid;
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] v1;
    logic [DATA_W-1:0] v2;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] pc;
    logic [TAG_W-1:0]  tag;
  } iss_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  rs_issue_sched_if #(.OP_W(OP_W), .DATA_W(DATA_W), .TAG_W(TAG_W)) bus ();

  rs_issue_sched #(.ENTRIES(ENTRIES), .OP_W(OP_W), .DATA_W(DATA_W), .TAG_W(TAG_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .sif  (bus.slave)
  );

  ent_t m [ENTRIES];
  iss_t exp_iss;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  task automatic chk(input string name, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, want);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < ENTRIES; i++) m[i].busy = 1'b0;
    exp_iss = '0;
  endfunction

  function automatic logic model_full();
    logic f = 1'b1;
    for (int i = 0; i < ENTRIES; i++) f = f & m[i].busy;
    return f;
  endfunction

  // One clock edge of the station: pick the oldest-index ready entry from the
  // state before the edge, then apply broadcast and dispatch.
  function automatic void model_edge();
    int sel = -1;
    int fr  = -1;
    for (int i = 0; i < ENTRIES; i++) begin
      if (sel < 0 && m[i].busy && !m[i].b1 && !m[i].b2) sel = i;
      if (fr < 0 && !m[i].busy) fr = i;
    end
    if (bus.flush) begin
      model_reset();
      return;
    end
    exp_iss = '0;
    if (sel >= 0) begin
      exp_iss.valid = 1'b1;
      exp_iss.op    = m[sel].op;
      exp_iss.v1    = m[sel].v1;
      exp_iss.v2    = m[sel].v2;
      exp_iss.imm   = m[sel].imm;
      exp_iss.pc    = m[sel].pc;
      exp_iss.tag   = m[sel].tag;
      m[sel].busy   = 1'b0;
    end
    if (bus.cdb_valid) begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (m[i].busy && m[i].b1 && m[i].q1 == bus.cdb_tag) begin m[i].v1 = bus.cdb_data; m[i].b1 = 1'b0; end
        if (m[i].busy && m[i].b2 && m[i].q2 == bus.cdb_tag) begin m[i].v2 = bus.cdb_data; m[i].b2 = 1'b0; end
      end
    end
    if (bus.disp_valid && fr >= 0) begin
      m[fr].busy = 1'b1;
      m[fr].op   = bus.disp_op;
      m[fr].imm  = bus.disp_imm;
      m[fr].pc   = bus.disp_pc;
      m[fr].tag  = bus.disp_tag;
      m[fr].q1   = bus.disp_q1;
      m[fr].q2   = bus.disp_q2;
      m[fr].v1   = bus.disp_v1;
      m[fr].v2   = bus.disp_v2;
      m[fr].b1   = bus.disp_b1;
      m[fr].b2   = bus.disp_b2;
      if (bus.cdb_valid && bus.disp_b1 && bus.disp_q1 == bus.cdb_tag) begin m[fr].v1 = bus.cdb_data; m[fr].b1 = 1'b0; end
      if (bus.cdb_valid && bus.disp_b2 && bus.disp_q2 == bus.cdb_tag) begin m[fr].v2 = bus.cdb_data; m[fr].b2 = 1'b0; end
    end
  endfunction

  task automatic idle();
    bus.flush = 1'b0; bus.disp_valid = 1'b0; bus.cdb_valid = 1'b0;
    bus.disp_op = '0; bus.disp_v1 = '0; bus.disp_v2 = '0; bus.disp_q1 = '0; bus.disp_q2 = '0;
    bus.disp_b1 = 1'b0; bus.disp_b2 = 1'b0; bus.disp_imm = '0; bus.disp_pc = '0; bus.disp_tag = '0;
    bus.cdb_tag = '0; bus.cdb_data = '0;
  endtask

  task automatic set_disp(input logic [OP_W-1:0] op, input logic [DATA_W-1:0] v1, input logic [DATA_W-1:0] v2,
                          input logic [TAG_W-1:0] q1, input logic [TAG_W-1:0] q2,
                          input logic b1, input logic b2, input logic [TAG_W-1:0] tag);
    bus.disp_valid = 1'b1; bus.disp_op = op; bus.disp_v1 = v1; bus.disp_v2 = v2;
    bus.disp_q1 = q1; bus.disp_q2 = q2; bus.disp_b1 = b1; bus.disp_b2 = b2; bus.disp_tag = tag;
    bus.disp_imm = $urandom; bus.disp_pc = $urandom;
  endtask

  task automatic set_cdb(input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] d);
    bus.cdb_valid = 1'b1; bus.cdb_tag = t; bus.cdb_data = d;
  endtask

  // Check full, take one edge, compare the whole issue bundle to the model.
  task automatic step();
    chk("full", DATA_W'(bus.full), DATA_W'(model_full()));
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
    chk("iss_valid", DATA_W'(bus.iss_valid), DATA_W'(exp_iss.valid));
    chk("iss_op",    DATA_W'(bus.iss_op),    DATA_W'(exp_iss.op));
    chk("iss_v1",    bus.iss_v1,             exp_iss.v1);
    chk("iss_v2",    bus.iss_v2,             exp_iss.v2);
    chk("iss_imm",   bus.iss_imm,            exp_iss.imm);
    chk("iss_pc",    bus.iss_pc,             exp_iss.pc);
    chk("iss_tag",   DATA_W'(bus.iss_tag),   DATA_W'(exp_iss.tag));
  endtask

  initial begin
    idle();
    model_reset();
    #1 rst_n = 1'b0;
    #2;
    chk("rst_iss_valid", DATA_W'(bus.iss_valid), 0);
    chk("rst_iss_op",    DATA_W'(bus.iss_op),    0);
    chk("rst_iss_v1",    bus.iss_v1,             0);
    chk("rst_full",      DATA_W'(bus.full),      0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Ready ADD issues one cycle after dispatch, for exactly one cycle.
    set_disp(OP_ADD, 32'd5, 32'd7, 4'd0, 4'd0, 1'b0, 1'b0, 4'd3);
    step();
    idle();
    step();
    chk("add_valid", DATA_W'(bus.iss_valid), 1);
    chk("add_op",    DATA_W'(bus.iss_op),    DATA_W'(OP_ADD));
    chk("add_v1",    bus.iss_v1,             5);
    chk("add_v2",    bus.iss_v2,             7);
    chk("add_tag",   DATA_W'(bus.iss_tag),   3);
    step();
    chk("add_drop", DATA_W'(bus.iss_valid), 0);

    // Operand 1 waits on tag 2, woken after three idle cycles.
    set_disp(6'd2, 32'd0, 32'd9, 4'd2, 4'd0, 1'b1, 1'b0, 4'd5);
    step();
    idle();
    repeat (3) step();
    chk("wait_idle", DATA_W'(bus.iss_valid), 0);
    set_cdb(4'd2, 32'h1234);
    step();
    idle();
    step();
    chk("wake_valid", DATA_W'(bus.iss_valid), 1);
    chk("wake_v1",    bus.iss_v1,             32'h1234);

    // Operand 2 bypassed from the CDB at dispatch.
    set_disp(6'd3, 32'd1, 32'd0, 4'd0, 4'd6, 1'b0, 1'b1, 4'd7);
    set_cdb(4'd6, 32'hAA);
    step();
    idle();
    step();
    chk("byp_valid", DATA_W'(bus.iss_valid), 1);
    chk("byp_v2",    bus.iss_v2,             32'hAA);

    // Fill every slot blocked on tag 9; a ninth dispatch is dropped.
    for (int i = 0; i < ENTRIES; i++) begin
      set_disp(6'd4, 32'd0, 32'(i), 4'd9, 4'd0, 1'b1, 1'b0, 4'(i));
      step();
    end
    chk("fill_full", DATA_W'(bus.full), 1);
    set_disp(6'd5, 32'd0, 32'd0, 4'd9, 4'd0, 1'b1, 1'b0, 4'd15);
    step();
    idle();
    set_cdb(4'd9, 32'hBEEF);
    step();
    idle();
    for (int i = 0; i < ENTRIES; i++) begin
      step();
      chk("order_tag", DATA_W'(bus.iss_tag), DATA_W'(i));
      if (i == 0) chk("full_drop", DATA_W'(bus.full), 0);
    end
    step();
    chk("fill_empty", DATA_W'(bus.iss_valid), 0);

    // Slots 1 and 4 woken together; refill of slot 1 issues after slot 4.
    for (int i = 0; i < 5; i++) begin
      set_disp(6'd6, 32'd0, 32'd0, (i == 1 || i == 4) ? 4'd12 : 4'd11, 4'd0, 1'b1, 1'b0, 4'(i));
      step();
    end
    idle();
    set_cdb(4'd12, 32'h55);
    step();
    idle();
    step();
    chk("two_first", DATA_W'(bus.iss_tag), 1);
    set_disp(6'd7, 32'd3, 32'd4, 4'd0, 4'd0, 1'b0, 1'b0, 4'd13);
    step();
    chk("two_second", DATA_W'(bus.iss_tag), 4);
    idle();
    step();
    chk("refill_tag", DATA_W'(bus.iss_tag), 13);

    // Five busy slots, then flush with dispatch and a matching broadcast.
    for (int i = 0; i < 2; i++) begin
      set_disp(6'd8, 32'd0, 32'd0, 4'd11, 4'd0, 1'b1, 1'b0, 4'd10);
      step();
    end
    idle();
    bus.flush = 1'b1;
    set_disp(6'd9, 32'd0, 32'd0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd14);
    set_cdb(4'd11, 32'h77);
    step();
    idle();
    chk("flush_full", DATA_W'(bus.full), 0);
    chk("flush_valid", DATA_W'(bus.iss_valid), 0);
    for (int i = 0; i < 5; i++) step();

    // Asynchronous reset pulse clears a live issue immediately.
    set_disp(6'd10, 32'd1, 32'd2, 4'd0, 4'd0, 1'b0, 1'b0, 4'd2);
    step();
    idle();
    step();
    chk("pre_rst_valid", DATA_W'(bus.iss_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", DATA_W'(bus.iss_valid), 0);
    chk("async_rst_full",  DATA_W'(bus.full),      0);
    model_reset();
    @(posedge clk);
    #3 rst_n = 1'b1;

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      idle();
      if ($urandom_range(1, 0) == 1)
        set_disp(OP_W'($urandom_range(63, 1)), $urandom, $urandom,
                 TAG_W'($urandom_range(3, 0)), TAG_W'($urandom_range(3, 0)),
                 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), TAG_W'($urandom));
      if ($urandom_range(1, 0) == 1) set_cdb(TAG_W'($urandom_range(3, 0)), $urandom);
      bus.flush = ($urandom_range(39, 0) == 0);
      step();
    end
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
